// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants, request/state types and a signed-range helper
// shared by the instruction encoder/loader and the decode-side controller.
package rv_isa_pkg;

   typedef enum logic [2:0] {
      CLS_R      = 3'd0,
      CLS_IALU   = 3'd1,
      CLS_LW     = 3'd2,
      CLS_SW     = 3'd3,
      CLS_BRANCH = 3'd4,
      CLS_JAL    = 3'd5,
      CLS_JALR   = 3'd6,
      CLS_LUI    = 3'd7
   } req_class_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [31:0] NOP_WORD = 32'h00000013;

   typedef struct packed {
      req_class_e  cls;
      logic [2:0]  f3;
      logic        f7b5;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } enc_req_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } ld_state_e;

   // True when v is representable as a bits-wide two's-complement value.
   function automatic logic fits_s(input logic [31:0] v, input int unsigned bits);
      logic signed [31:0] lim;
      lim = 32'sd1 <<< (bits - 1);
      return ($signed(v) >= -lim) && ($signed(v) < lim);
   endfunction

endpackage

// File: rtl/rv_encode_comb.sv
// Pure combinational RV32I field encoder; illegal requests yield NOP_WORD
// and raise illegal_o.
module rv_encode_comb #(
   parameter logic [31:0] NOP_WORD = rv_isa_pkg::NOP_WORD
) (
   input  rv_isa_pkg::enc_req_t req_i,
   output logic [31:0]          word_o,
   output logic                 illegal_o
);
   import rv_isa_pkg::*;

   logic [31:0] imm;
   logic [31:0] w;
   logic        bad;

   assign imm = req_i.imm;

   always_comb begin
      w   = NOP_WORD;
      bad = 1'b0;
      unique case (req_i.cls)
         CLS_R: w = {(req_i.f7b5 ? 7'b0100000 : 7'b0000000), req_i.rs2, req_i.rs1,
                     req_i.f3, req_i.rd, OP_R};
         CLS_IALU: begin
            if (req_i.f3 == 3'b001 || req_i.f3 == 3'b101) begin
               // shifts carry shamt in imm[4:0]; negative imm compares large
               w   = {1'b0, req_i.f7b5, 5'b00000, imm[4:0], req_i.rs1, req_i.f3,
                      req_i.rd, OP_IMM};
               bad = (imm > 32'd31);
            end else begin
               w   = {imm[11:0], req_i.rs1, req_i.f3, req_i.rd, OP_IMM};
               bad = !fits_s(imm, 12);
            end
         end
         CLS_LW: begin
            w   = {imm[11:0], req_i.rs1, 3'b010, req_i.rd, OP_LOAD};
            bad = !fits_s(imm, 12);
         end
         CLS_SW: begin
            w   = {imm[11:5], req_i.rs2, req_i.rs1, 3'b010, imm[4:0], OP_STORE};
            bad = !fits_s(imm, 12);
         end
         CLS_BRANCH: begin
            w   = {imm[12], imm[10:5], req_i.rs2, req_i.rs1, req_i.f3, imm[4:1],
                   imm[11], OP_BRANCH};
            bad = imm[0] || !fits_s(imm, 13) || (req_i.f3 == 3'b010) ||
                  (req_i.f3 == 3'b011);
         end
         CLS_JAL: begin
            w   = {imm[20], imm[10:1], imm[11], imm[19:12], req_i.rd, OP_JAL};
            bad = imm[0] || !fits_s(imm, 21);
         end
         CLS_JALR: begin
            w   = {imm[11:0], req_i.rs1, 3'b000, req_i.rd, OP_JALR};
            bad = !fits_s(imm, 12);
         end
         CLS_LUI: begin
            w   = {imm[31:12], req_i.rd, OP_LUI};
            bad = (imm[11:0] != 12'd0);
         end
      endcase
      word_o    = bad ? NOP_WORD : w;
      illegal_o = bad;
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts field-level instruction requests, encodes them through one
// registered stage and writes the words sequentially from a base address.
module instr_encoder_loader #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DEPTH    = 1024,
   parameter logic [31:0] NOP_WORD = 32'h00000013,
   localparam int unsigned CW      = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_last,
   input  logic [2:0]        req_class,
   input  logic [2:0]        req_f3,
   input  logic              req_f7b5,
   input  logic [4:0]        req_rd,
   input  logic [4:0]        req_rs1,
   input  logic [4:0]        req_rs2,
   input  logic [31:0]       req_imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic [CW-1:0]     word_count,
   output logic              err
);
   import rv_isa_pkg::*;

   ld_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              wr_q, wr_d;
   logic [31:0]       wdata_q, wdata_d;

   enc_req_t          req;
   logic [31:0]       enc_word;
   logic              enc_ill;
   logic [CW:0]       cnt_next;
   logic [ADDR_W-1:0] base_aligned;
   logic              ready, accept;

   assign req.cls  = req_class_e'(req_class);
   assign req.f3   = req_f3;
   assign req.f7b5 = req_f7b5;
   assign req.rd   = req_rd;
   assign req.rs1  = req_rs1;
   assign req.rs2  = req_rs2;
   assign req.imm  = req_imm;

   rv_encode_comb #(.NOP_WORD(NOP_WORD)) u_enc (
      .req_i     (req),
      .word_o    (enc_word),
      .illegal_o (enc_ill)
   );

   // Count the in-flight write so a full run never accepts DEPTH+1 words.
   assign cnt_next     = {1'b0, cnt_q} + (CW+1)'(wr_q);
   assign ready        = (state_q == ST_RUN) && (cnt_next < (CW+1)'(DEPTH));
   assign accept       = req_valid && ready;
   assign base_aligned = base_addr & ~ADDR_W'(3);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      wr_d    = accept;
      wdata_d = wdata_q;
      if (wr_q) begin
         addr_d = addr_q + ADDR_W'(4);
         cnt_d  = cnt_q + CW'(1);
      end
      if (accept) begin
         wdata_d = enc_word;
         if (enc_ill) err_d = 1'b1;
      end
      unique case (state_q)
         ST_IDLE: if (start) begin
            state_d = ST_RUN;
            addr_d  = base_aligned;
            cnt_d   = '0;
            err_d   = 1'b0;
         end
         ST_RUN: begin
            if (accept && req_last) begin
               state_d = ST_DRAIN;
            end else if (req_valid && !ready) begin
               // saturated: flag overflow; a last request closes the run unwritten
               err_d = 1'b1;
               if (req_last) state_d = ST_DONE;
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
      end
   end

   assign req_ready  = ready;
   assign mem_we     = wr_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);
   assign word_count = cnt_q;
   assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench: encoding table, directed timing/saturation/reset
// sequences and randomized runs against an arithmetic reference model.
module tb_instr_encoder_loader;

   localparam int DEPTH = 4;

   typedef struct {
      logic [2:0]  cls;
      logic [2:0]  f3;
      logic        f7b5;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } req_t;

   typedef struct {
      req_t        r;
      logic [31:0] exp_word;
      bit          exp_ill;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_last = 1'b0;
   logic [2:0]  req_class = '0;
   logic [2:0]  req_f3 = '0;
   logic        req_f7b5 = 1'b0;
   logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
   logic [31:0] req_imm = '0;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        busy, done, err;
   logic [2:0]  word_count;

   instr_encoder_loader #(.ADDR_W(32), .DEPTH(DEPTH), .NOP_WORD(32'h00000013)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
      .req_class(req_class), .req_f3(req_f3), .req_f7b5(req_f7b5),
      .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .word_count(word_count), .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0;
   int done_cnt = 0;
   logic [31:0] ma[$], md[$];
   int          mc[$];
   req_t        rq[$];
   logic [31:0] ew[$];

   always @(negedge clk) begin
      cyc++;
      if (mem_we) begin
         ma.push_back(mem_addr);
         md.push_back(mem_wdata);
         mc.push_back(cyc);
      end
      if (done) done_cnt++;
   end

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // Reference encoder built from the ISA field layout using shifts/masks.
   function automatic void model(input req_t r, output logic [31:0] w, output bit ill);
      int s;
      logic [31:0] i, rd, rs1, rs2, f3;
      i = r.imm; s = $signed(r.imm);
      rd = 32'(r.rd) << 7; rs1 = 32'(r.rs1) << 15; rs2 = 32'(r.rs2) << 20;
      f3 = 32'(r.f3) << 12;
      ill = 1'b0;
      case (r.cls)
         3'd0: w = (r.f7b5 ? 32'h40000000 : 32'h0) | rs2 | rs1 | f3 | rd | 32'h33;
         3'd1: if (r.f3 == 3'd1 || r.f3 == 3'd5) begin
                  ill = (s < 0) || (s > 31);
                  w = (32'(r.f7b5) << 30) | ((i & 32'h1f) << 20) | rs1 | f3 | rd | 32'h13;
               end else begin
                  ill = (s < -2048) || (s > 2047);
                  w = ((i & 32'hfff) << 20) | rs1 | f3 | rd | 32'h13;
               end
         3'd2: begin
                  ill = (s < -2048) || (s > 2047);
                  w = ((i & 32'hfff) << 20) | rs1 | (32'd2 << 12) | rd | 32'h03;
               end
         3'd3: begin
                  ill = (s < -2048) || (s > 2047);
                  w = (((i >> 5) & 32'h7f) << 25) | rs2 | rs1 | (32'd2 << 12) |
                      ((i & 32'h1f) << 7) | 32'h23;
               end
         3'd4: begin
                  ill = (s % 2 != 0) || (s < -4096) || (s > 4094) || r.f3 == 3'd2 || r.f3 == 3'd3;
                  w = (((i >> 12) & 1) << 31) | (((i >> 5) & 32'h3f) << 25) | rs2 | rs1 | f3 |
                      (((i >> 1) & 32'hf) << 8) | (((i >> 11) & 1) << 7) | 32'h63;
               end
         3'd5: begin
                  ill = (s % 2 != 0) || (s < -1048576) || (s > 1048574);
                  w = (((i >> 20) & 1) << 31) | (((i >> 1) & 32'h3ff) << 21) |
                      (((i >> 11) & 1) << 20) | (((i >> 12) & 32'hff) << 12) | rd | 32'h6f;
               end
         3'd6: begin
                  ill = (s < -2048) || (s > 2047);
                  w = ((i & 32'hfff) << 20) | rs1 | rd | 32'h67;
               end
         default: begin
                  ill = (i & 32'hfff) != 0;
                  w = (i & 32'hfffff000) | rd | 32'h37;
               end
      endcase
      if (ill) w = 32'h00000013;
   endfunction

   function automatic req_t mk(int c, int f, int b, int d, int s1, int s2, logic [31:0] im);
      req_t r;
      r.cls = 3'(c); r.f3 = 3'(f); r.f7b5 = 1'(b);
      r.rd = 5'(d); r.rs1 = 5'(s1); r.rs2 = 5'(s2); r.imm = im;
      return r;
   endfunction

   task automatic push(input req_t r, input bit last, output bit acc);
      req_class = r.cls; req_f3 = r.f3; req_f7b5 = r.f7b5;
      req_rd = r.rd; req_rs1 = r.rs1; req_rs2 = r.rs2; req_imm = r.imm;
      req_valid = 1'b1; req_last = last;
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1;
   endtask

   task automatic do_start(input logic [31:0] base);
      start = 1'b1; base_addr = base;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Streams rq back-to-back in one run and checks writes against ew.
   task automatic run_prog(input logic [31:0] base, input bit exp_err, input string tag);
      int n, nw;
      bit acc;
      n = rq.size();
      nw = (n < DEPTH) ? n : DEPTH;
      ma.delete(); md.delete(); mc.delete(); done_cnt = 0;
      do_start(base);
      @(negedge clk);
      check({tag, " err_clr"}, 32'(err), 0);
      check({tag, " busy"}, 32'(busy), 1);
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         push(rq[i], i == n - 1, acc);
         check($sformatf("%s ready[%0d]", tag, i), 32'(acc), 32'(i < DEPTH));
      end
      req_valid = 1'b0; req_last = 1'b0;
      for (int c = 0; c < 10 && done_cnt == 0; c++) @(negedge clk);
      @(negedge clk); @(negedge clk);
      check({tag, " done_once"}, 32'(done_cnt), 1);
      check({tag, " idle"}, 32'(busy), 0);
      check({tag, " nwrites"}, 32'(ma.size()), 32'(nw));
      for (int i = 0; i < nw && i < ma.size(); i++) begin
         check($sformatf("%s addr[%0d]", tag, i), ma[i], (base & ~32'd3) + 32'(4 * i));
         check($sformatf("%s data[%0d]", tag, i), md[i], ew[i]);
         check($sformatf("%s cycle[%0d]", tag, i), 32'(mc[i]), 32'(mc[0] + i));
      end
      check({tag, " err"}, 32'(err), 32'(exp_err));
      check({tag, " word_count"}, 32'(word_count), 32'(nw));
   endtask

   vec_t tbl[$];

   initial begin
      bit acc, ill, any_ill;
      logic [31:0] w;
      int n;

      tbl.push_back('{mk(0,0,0,3,1,2,32'd0),          32'h002081B3, 0});
      tbl.push_back('{mk(1,0,0,1,0,0,32'd5),          32'h00500093, 0});
      tbl.push_back('{mk(0,0,1,3,1,2,32'd0),          32'h402081B3, 0});
      tbl.push_back('{mk(3,0,0,0,1,2,32'd4),          32'h0020A223, 0});
      tbl.push_back('{mk(2,0,0,2,1,0,32'd4),          32'h0040A103, 0});
      tbl.push_back('{mk(4,0,0,0,1,2,32'd8),          32'h00208463, 0});
      tbl.push_back('{mk(5,0,0,1,0,0,32'd16),         32'h010000EF, 0});
      tbl.push_back('{mk(7,0,0,5,0,0,32'h12345000),   32'h123452B7, 0});
      tbl.push_back('{mk(1,5,1,4,4,0,32'd3),          32'h40325213, 0});
      tbl.push_back('{mk(6,0,0,1,5,0,32'hFFFFFFFC),   32'hFFC280E7, 0});
      tbl.push_back('{mk(5,0,0,0,0,0,32'hFFF00000),   32'h8000006F, 0});
      tbl.push_back('{mk(1,0,0,1,0,0,32'hFFFFF800),   32'h80000093, 0});
      tbl.push_back('{mk(4,1,0,0,0,0,32'd4094),       32'h7E001FE3, 0});
      tbl.push_back('{mk(4,0,0,0,1,2,32'd7),          32'h00000013, 1});
      tbl.push_back('{mk(1,0,0,1,0,0,32'd4096),       32'h00000013, 1});
      tbl.push_back('{mk(1,1,0,1,1,0,32'd32),         32'h00000013, 1});
      tbl.push_back('{mk(4,2,0,0,1,2,32'd8),          32'h00000013, 1});
      tbl.push_back('{mk(7,0,0,5,0,0,32'h00001001),   32'h00000013, 1});

      // reset state
      repeat (2) @(negedge clk);
      check("rst mem_we", 32'(mem_we), 0);
      check("rst mem_addr", mem_addr, 0);
      check("rst mem_wdata", mem_wdata, 0);
      check("rst busy", 32'(busy), 0);
      check("rst done", 32'(done), 0);
      check("rst word_count", 32'(word_count), 0);
      check("rst err", 32'(err), 0);
      check("rst ready", 32'(req_ready), 0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;

      // single request: write latency and done timing
      ma.delete(); md.delete(); mc.delete();
      do_start(32'h101);
      push(tbl[0].r, 1'b1, acc);
      req_valid = 1'b0; req_last = 1'b0;
      check("t1 accepted", 32'(acc), 1);
      @(negedge clk);
      check("t1 we", 32'(mem_we), 1);
      check("t1 addr", mem_addr, 32'h100);
      check("t1 wdata", mem_wdata, 32'h002081B3);
      check("t1 done_early", 32'(done), 0);
      @(negedge clk);
      check("t1 done", 32'(done), 1);
      check("t1 we_off", 32'(mem_we), 0);
      @(negedge clk);
      check("t1 done_pulse", 32'(done), 0);
      check("t1 busy", 32'(busy), 0);
      check("t1 word_count", 32'(word_count), 1);

      // encoding table, one request per run; err must stay sticky while idle
      foreach (tbl[k]) begin
         rq.delete(); ew.delete();
         rq.push_back(tbl[k].r); ew.push_back(tbl[k].exp_word);
         run_prog(32'h1000 + 32'(k * 64), tbl[k].exp_ill, $sformatf("tbl%0d", k));
         if (tbl[k].exp_ill) begin
            repeat (3) @(negedge clk);
            check($sformatf("tbl%0d err_sticky", k), 32'(err), 1);
         end
      end

      // back-to-back stream of four
      rq.delete(); ew.delete();
      for (int k = 1; k <= 4; k++) begin
         rq.push_back(tbl[k].r); ew.push_back(tbl[k].exp_word);
      end
      run_prog(32'h200, 1'b0, "stream");

      // saturation: six requests into a four-word run
      rq.delete(); ew.delete();
      for (int k = 0; k < 6; k++) begin
         rq.push_back(tbl[k % 5].r);
         if (k < DEPTH) ew.push_back(tbl[k % 5].exp_word);
      end
      run_prog(32'h400, 1'b1, "sat");

      // reset between accept and write
      ma.delete(); done_cnt = 0;
      do_start(32'h300);
      push(tbl[1].r, 1'b0, acc);
      req_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check("rstmid accepted", 32'(acc), 1);
      check("rstmid writes", 32'(ma.size()), 0);
      check("rstmid busy", 32'(busy), 0);
      check("rstmid addr", mem_addr, 0);
      check("rstmid wdata", mem_wdata, 0);
      check("rstmid err", 32'(err), 0);
      check("rstmid word_count", 32'(word_count), 0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
      rq.delete(); ew.delete();
      rq.push_back(tbl[7].r); ew.push_back(tbl[7].exp_word);
      run_prog(32'h300, 1'b0, "post_rst");

      // randomized runs against the reference model
      for (int t = 0; t < 40; t++) begin
         rq.delete(); ew.delete();
         any_ill = 1'b0;
         n = $urandom_range(1, 6);
         for (int k = 0; k < n; k++) begin
            req_t r;
            logic [31:0] im;
            case ($urandom_range(0, 4))
               0: im = 32'($urandom_range(0, 80)) - 32'd40;
               1: im = $urandom;
               2: im = $urandom & 32'hFFFFF000;
               3: im = 32'($urandom_range(0, 8192)) - 32'd4096;
               default: im = 32'($urandom_range(0, 4096)) - 32'd2048;
            endcase
            r = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), im);
            rq.push_back(r);
            if (k < DEPTH) begin
               model(r, w, ill);
               ew.push_back(w);
               any_ill |= ill;
            end
         end
         run_prog(32'($urandom) & 32'h0000FFFF, any_ill || (n > DEPTH), $sformatf("rnd%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
